muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit, parametrised in data width, that sits beside the single-cycle ALU in the execute stage. It executes all eight M-extension operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It uses a radix-2 shift-add/restoring-subtract datapath behind a valid/ready handshake. It carries the destination register tag so writeback can retire the result when it completes.

## Interface
- XLEN, 32: operand/result width; any even value ≥ 8.
- clk  in  1  clock. One clock domain only; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  type_MulDivOp  operation (funct3 encoding).
- in_rs1  in  XLEN  operand A (dividend / multiplicand).
- in_rs2  in  XLEN  operand B (divisor / multiplier).
- in_rd  in  type_RegAddr  destination tag, passed through to out_rd.
- flush  in  1  abort any in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  result.
- out_rd  out  type_RegAddr  tag of the result.

## Operation
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch the op and in_rd, convert the signed operands to magnitudes, and record the result sign(s).
  - Go to CALC and load the step counter with XLEN−1.
- Signedness of operands:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MUL, MULHU, DIVU, REMU: both operands unsigned magnitudes. MUL's low bits are sign-agnostic.
- CALC, one step per cycle:
  - Multiply: 2·XLEN-bit accumulator shift-add.
  - Divide: restoring shift-subtract producing XLEN quotient bits; the remainder is the partial remainder.
  - When the counter reaches 0, go to FIXUP.
- FIXUP:
  - Apply negation: product sign = signA ^ signB; quotient sign = signA ^ signB; remainder sign = signA.
  - Select the result: low product half (MUL), high product half (MULH*), quotient, or remainder.
  - Go to DONE.
- DONE: out_valid=1, and out_result and out_rd are held stable. On out_ready, go to IDLE.
- Special division cases are detected in IDLE at accept time. They skip CALC and go straight to FIXUP:
  - Divide by zero: quotient = all ones; remainder = rs1 unchanged.
  - Signed overflow (DIV/REM with rs1 = −2^(XLEN−1) and rs2 = −1): quotient = rs1; remainder = 0.
- flush: from any state, the next state is IDLE. Any pending out_valid is dropped and nothing is emitted. flush has priority over in_valid and out_ready in the same cycle.
- rst_n=0 (reset, including mid-operation):
  - State → IDLE.
  - in_ready=1 after reset.
  - out_valid=0.
  - out_result=0.
  - out_rd=0.
  - Counter and accumulators are cleared.

## Timing
- in_ready = (state==IDLE). The unit accepts no new request while a result is pending, so there is no pipelining.
- Normal latency: accept at cycle t, then out_valid at t+XLEN+2 (XLEN CALC cycles + 1 FIXUP cycle + registered DONE).
- Special divide cases: out_valid at t+2.
- The earliest next accept is the cycle after the out_valid && out_ready handshake. Back-to-back throughput is one op per XLEN+3 cycles.
- Outputs are registered. out_result and out_rd do not change while out_valid=1 and out_ready=0.
- The sign of a zero result is never negated: −0 = 0.

## Structure
- Shared package additions:
  - type_MulDivOp enum {MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7}.
  - Constant MULDIV_FUNCT7 = 7'b0000001.
  - getMulDivOp(ins) returning ins[14:12].
  - isMulDiv(ins): opcode==OP && funct7==MULDIV_FUNCT7.
- FSM state enum: local to the module.
- No sub-module. The shared XLEN+1-bit adder/subtractor, the counter and the FSM all live in one module.

## Test plan
- XLEN=32, MUL rs1=7, rs2=0xFFFFFFFD → out_result 0xFFFFFFEB at t+34; out_rd echoes in_rd=5.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM 0xFFFFFFF9/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF at t+2. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid → result and out_rd stable, in_ready=0; accept occurs the cycle after the handshake.
- Abort: assert flush at CALC cycle 10 → IDLE next cycle, no out_valid. Repeat with rst_n=0 mid-CALC → all outputs 0 and in_ready=1 after reset. A fresh MUL 3×4 afterwards → 12.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M definitions: multiply/divide operation encoding and instruction decode helpers.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } type_MulDivOp;

    typedef logic [4:0] type_RegAddr;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    function automatic type_MulDivOp getMulDivOp(input logic [31:0] ins);
        return type_MulDivOp'(ins[14:12]);
    endfunction

    function automatic logic isMulDiv(input logic [31:0] ins);
        return (ins[6:0] == OPCODE_OP) && (ins[31:25] == MULDIV_FUNCT7);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply and restoring divide over
// magnitudes, with sign fix-up and a registered result behind valid/ready handshakes.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  type_MulDivOp    in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  type_RegAddr     in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output type_RegAddr     out_rd
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t            state, state_next;
    type_MulDivOp      op_q;
    type_RegAddr       rd_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic              neg_q;

    // Accept-time decode
    logic            accept, in_is_div, sign_a, sign_b, div_zero, div_ovf, neg_in;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        in_is_div = in_op inside {DIV, DIVU, REM, REMU};
        sign_a    = (in_op inside {MULH, MULHSU, DIV, REM}) && in_rs1[XLEN-1];
        sign_b    = (in_op inside {MULH, DIV, REM}) && in_rs2[XLEN-1];
        mag_a     = sign_a ? -in_rs1 : in_rs1;
        mag_b     = sign_b ? -in_rs2 : in_rs2;
        div_zero  = in_is_div && (in_rs2 == '0);
        div_ovf   = (in_op inside {DIV, REM}) && (in_rs1 == MIN_INT) && (in_rs2 == '1);
        neg_in    = (in_op == REM) ? sign_a : (sign_a ^ sign_b);
        accept    = in_valid && (state == IDLE) && !flush;
    end

    // One shared XLEN+1-bit adder: adds the multiplicand or subtracts the divisor.
    logic              op_is_div, carry;
    logic [XLEN:0]     add_a, add_b;
    logic [XLEN+1:0]   sum;
    logic [XLEN-1:0]   rem_new;
    logic [2*XLEN-1:0] acc_step, product;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        op_is_div = op_q inside {DIV, DIVU, REM, REMU};
        if (op_is_div) begin
            add_a = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
            add_b = ~{1'b0, opb};
        end else begin
            add_a = {1'b0, acc[2*XLEN-1:XLEN]};
            add_b = {1'b0, opb};
        end
        sum     = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, op_is_div};
        carry   = sum[XLEN+1];
        rem_new = carry ? sum[XLEN-1:0] : add_a[XLEN-1:0];

        if (op_is_div)
            acc_step = {rem_new, acc[XLEN-2:0], carry};
        else if (acc[0])
            acc_step = {sum[XLEN:0], acc[XLEN-1:1]};
        else
            acc_step = {1'b0, acc[2*XLEN-1:XLEN], acc[XLEN-1:1]};

        product = neg_q ? -acc : acc;
        case (op_q)
            MUL:               fix_result = acc[XLEN-1:0];
            MULH, MULHSU,
            MULHU:             fix_result = product[2*XLEN-1:XLEN];
            DIV, DIVU:         fix_result = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            default:           fix_result = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        endcase
    end

    // NOTE: every comb output gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = (div_zero || div_ovf) ? FIXUP : CALC;
            CALC:    if (cnt == '0) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= MUL;
            rd_q       <= '0;
            cnt        <= '0;
            acc        <= '0;
            opb        <= '0;
            neg_q      <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
        end else begin
            if (accept) begin
                op_q  <= in_op;
                rd_q  <= in_rd;
                cnt   <= CW'(XLEN-1);
                opb   <= in_is_div ? mag_b : mag_a;
                neg_q <= neg_in;
                // Special divides preload the final {remainder, quotient} and skip CALC.
                if (div_zero) begin
                    acc   <= {in_rs1, {XLEN{1'b1}}};
                    neg_q <= 1'b0;
                end else if (div_ovf) begin
                    acc   <= {{XLEN{1'b0}}, in_rs1};
                    neg_q <= 1'b0;
                end else begin
                    acc <= {{XLEN{1'b0}}, in_is_div ? mag_a : mag_b};
                end
            end else if (state == CALC) begin
                acc <= acc_step;
                cnt <= cnt - CW'(1);
            end
            if (state == FIXUP && !flush) begin
                out_result <= fix_result;
                out_rd     <= rd_q;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32): results, latency, tag echo,
// back-pressure, flush and mid-operation reset.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    type_MulDivOp    in_op = MUL;
    logic [XLEN-1:0] in_rs1 = '0;
    logic [XLEN-1:0] in_rs2 = '0;
    type_RegAddr     in_rd = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_result;
    type_RegAddr     out_rd;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request in one cycle, then wait (bounded) for out_valid.
    task automatic issue(input type_MulDivOp op, input logic [31:0] a, input logic [31:0] b,
                         input type_RegAddr rd, output int lat);
        @(negedge clk);
        check("accept_ready", in_ready, 1);
        in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input type_MulDivOp op, input logic [31:0] a,
                          input logic [31:0] b, input type_RegAddr rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(op, a, b, rd, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, out_result, exp);
        check({tag, "_rd"}, out_rd, rd);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ack"}, out_valid, 0);
    endtask

    initial begin
        int lat;
        int seen;

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_rd", out_rd, 0);
        rst_n = 1'b1;

        run_op("mul",     MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34);
        run_op("mulh",    MULH,   32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 34);
        run_op("mulhu",   MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 34);
        run_op("mulhsu",  MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 34);
        run_op("div",     DIV,    32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 34);
        run_op("rem",     REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 34);
        run_op("divu",    DIVU,   32'd100,      32'd7,        5'd7,  32'd14,       34);
        run_op("remu",    REMU,   32'd100,      32'd7,        5'd8,  32'd2,        34);
        run_op("divu_z",  DIVU,   32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 2);
        run_op("rem_z",   REM,    32'd5,        32'd0,        5'd10, 32'd5,        2);
        run_op("div_ovf", DIV,    32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 2);
        run_op("rem_ovf", REM,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        2);
        run_op("rem_neg0", REM,   32'hFFFFFFFA, 32'd3,        5'd13, 32'd0,        34);

        // Back-pressure: result and tag must hold while out_ready stays low.
        issue(DIVU, 32'd1000, 32'd10, 5'd21, lat);
        check("bp_lat", lat, 34);
        in_valid = 1'b1; in_op = MUL; in_rs1 = 32'd9; in_rs2 = 32'd9; in_rd = 5'd22;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_res", out_result, 32'd100);
            check("bp_rd", out_rd, 21);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_next_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_accept", in_ready, 0);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("bp_next_lat", lat, 34);
        check("bp_next_res", out_result, 32'd81);
        check("bp_next_rd", out_rd, 22);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Flush at CALC cycle 10: back to IDLE, nothing emitted.
        @(negedge clk);
        in_valid = 1'b1; in_op = DIVU; in_rs1 = 32'd77; in_rs2 = 32'd7; in_rd = 5'd30;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("fl_busy", in_ready, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_in_ready", in_ready, 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("fl_no_valid", seen, 0);

        // Reset mid-CALC clears every output.
        @(negedge clk);
        in_valid = 1'b1; in_op = MULHU; in_rs1 = 32'h12345678; in_rs2 = 32'h9ABCDEF0; in_rd = 5'd31;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rs_in_ready", in_ready, 1);
        check("rs_out_valid", out_valid, 0);
        check("rs_out_result", out_result, 0);
        check("rs_out_rd", out_rd, 0);
        rst_n = 1'b1;

        run_op("mul_after", MUL, 32'd3, 32'd4, 5'd14, 32'd12, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
